sram_arbiter: RTL

- Multi-cycle controller for the 32-bit base SRAM, shared between the CPU instruction-fetch port and the data-memory port.
- Replaces the combinational steering in the board top level.
- Arbitrates requests with fixed priority, generates registered, glitch-free SRAM strobes with programmable wait states, and returns read data with a one-cycle acknowledge.
- Sits between the CPU core and the base_ram pins; the pipeline stalls on the stall_req output.

---
 rtl/sram_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Multi-cycle controller for the 32-bit base SRAM shared by instruction fetch and data memory.
// Fixed-priority arbitration with registered strobes, programmable wait states and a one-cycle ack.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        stall_req,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [31:0] ram_dq_o,
  output logic        ram_dq_oe,
  input  logic [31:0] ram_dq_i
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    WHOLD,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              owner_mem_reg, owner_mem_next;
  logic [19:0]       addr_reg, addr_next;
  logic [3:0]        be_n_reg, be_n_next;
  logic [31:0]       dq_o_reg, dq_o_next;
  logic              dq_oe_reg, dq_oe_next;
  logic              ce_n_reg, ce_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic              if_ack_reg, if_ack_next;
  logic              mem_ack_reg, mem_ack_next;
  logic [31:0]       if_rdata_reg, if_rdata_next;
  logic [31:0]       mem_rdata_reg, mem_rdata_next;
  logic [3:0]        sel_be_n;

  // Only word address bits 21:2 reach the 1M x 32 SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_be
      assign sel_be_n[gi] = ~mem_sel[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      owner_mem_reg <= 1'b0;
      addr_reg      <= '0;
      be_n_reg      <= 4'b1111;
      dq_o_reg      <= '0;
      dq_oe_reg     <= 1'b0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      if_ack_reg    <= 1'b0;
      mem_ack_reg   <= 1'b0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      owner_mem_reg <= owner_mem_next;
      addr_reg      <= addr_next;
      be_n_reg      <= be_n_next;
      dq_o_reg      <= dq_o_next;
      dq_oe_reg     <= dq_oe_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      if_ack_reg    <= if_ack_next;
      mem_ack_reg   <= mem_ack_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    owner_mem_next = owner_mem_reg;
    addr_next      = addr_reg;
    be_n_next      = be_n_reg;
    dq_o_next      = dq_o_reg;
    if_ack_next    = 1'b0;
    mem_ack_next   = 1'b0;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          owner_mem_next = 1'b1;
          addr_next      = mem_addr[21:2];
          be_n_next      = sel_be_n;
          dq_o_next      = mem_wdata;
          cnt_next       = CNT_W'(WAIT_CYCLES);
          state_next     = mem_we ? WRITE : READ;
        end else if (if_req) begin
          owner_mem_next = 1'b0;
          addr_next      = if_addr[21:2];
          be_n_next      = 4'b0000;
          dq_o_next      = mem_wdata;
          cnt_next       = CNT_W'(WAIT_CYCLES);
          state_next     = READ;
        end
      end
      READ: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          if (owner_mem_reg) begin
            mem_rdata_next = ram_dq_i;
            mem_ack_next   = 1'b1;
          end else begin
            if_rdata_next = ram_dq_i;
            if_ack_next   = 1'b1;
          end
          state_next = DONE;
        end
      end
      WRITE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = WHOLD;
        end
      end
      WHOLD: begin
        mem_ack_next = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes are registered from the state being entered so they change cleanly on the edge.
  always_comb begin
    ce_n_next  = 1'b1;
    oe_n_next  = 1'b1;
    we_n_next  = 1'b1;
    dq_oe_next = 1'b0;
    case (state_next)
      READ: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
      end
      WRITE: begin
        ce_n_next  = 1'b0;
        we_n_next  = 1'b0;
        dq_oe_next = 1'b1;
      end
      WHOLD: begin
        ce_n_next  = 1'b0;
        dq_oe_next = 1'b1;
      end
      default: begin
        ce_n_next = 1'b1;
      end
    endcase
  end

  assign stall_req = (if_req & ~if_ack_reg) | (mem_req & ~mem_ack_reg);

  assign if_ack    = if_ack_reg;
  assign mem_ack   = mem_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;
  assign ram_addr  = addr_reg;
  assign ram_be_n  = be_n_reg;
  assign ram_ce_n  = ce_n_reg;
  assign ram_oe_n  = oe_n_reg;
  assign ram_we_n  = we_n_reg;
  assign ram_dq_o  = dq_o_reg;
  assign ram_dq_oe = dq_oe_reg;

endmodule
